svec_vme_func_decoder: RTL and testbench
========================================

Name: svec_vme_func_decoder

Overview:
- VME64x CR/CSR configuration and address-decode block for the SVEC carrier top level.
- Holds the per-function ADER registers, the BIT_SET/BIT_CLR module-enable bit and one user control byte, all written by the host through CR/CSR byte accesses.
- Decodes each incoming VME address/AM pair to a function hit plus a local (in-window) address. These feed the Wishbone crossbar that reaches the TDC, VIC and node-CPU CSR windows.

Parameters:
- g_adem0, 32'hFF000000, func0 address-compare mask (A32, 16 MB window).
- g_adem1, 32'h00F80000, func1 address-compare mask (A24, 512 KB window at 0xC00000..0xC7FFFF).

Ports:
- clk_sys_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- csr_we_i  in  1  CR/CSR byte write strobe, single cycle.
- csr_re_i  in  1  CR/CSR byte read strobe, single cycle.
- csr_addr_i  in  19  CR/CSR byte address.
- csr_data_i  in  8  write data.
- csr_data_o  out  8  read data, valid with csr_ack_o.
- csr_ack_o  out  1  access acknowledge.
- dec_valid_i  in  1  decode request.
- dec_addr_i  in  32  VME address.
- dec_am_i  in  6  VME address modifier.
- dec_hit_o  out  1  request matched an enabled function.
- dec_func_o  out  1  matched function number.
- dec_local_addr_o  out  32  dec_addr_i AND NOT adem of the matched function.
- module_en_o  out  1  BIT_SET bit 4.
- user_ctrl_o  out  8  user control register.

Behaviour:
- Reset (rst_i=1, asynchronous): ADER0=ADER1=32'h00000001 (both disabled), module_en=0, user_ctrl=0. All outputs 0.
- CR/CSR map (byte lanes, big-endian inside each ADER):
  - ADERn at 0x7FF63+n*0x10. Offsets +0, +4, +8, +12 hold bits 31:24, 23:16, 15:8, 7:0.
  - 0x7FF33: user_ctrl.
  - 0x7FFFB: BIT_SET. Write sets the 1-bits; read returns {3'b0, module_en, 4'b0}.
  - 0x7FFF7: BIT_CLR. Write clears the 1-bits; read is the same as BIT_SET.
  - Bits other than bit 4 are ignored by both BIT_SET and BIT_CLR.
- CR/CSR access timing:
  - Any other address: writes are ignored and reads return 8'h00.
  - csr_ack_o pulses exactly one cycle, the cycle after a strobe, for every access including unmapped ones.
  - csr_data_o holds its value until the next read.
  - Writes take effect on the strobe edge. If csr_we_i and csr_re_i are both high, the write wins and the read data is the new value.
- ADER fields: bits 31:8 are the base, bits 7:2 are the AM, bit 0 is XAM/disable. A function is enabled iff bit0=0.
- Decode:
  - One-cycle registered latency. dec_valid_i in cycle N gives outputs in cycle N+1, and the outputs are held until the next request.
  - Function n matches iff module_en=1, ADERn enabled, (dec_addr_i & adem_n) == (ADERn & adem_n & 32'hFFFFFF00), and dec_am_i == ADERn[7:2].
  - If both functions match, func0 has priority.
  - No match gives hit=0, func=0, local_addr=0.
- ADER writes land one byte at a time, so a half-updated ADER is used as-is; software enables the module last.
- A reset mid-access drops any pending ack.

Test Plan:
- After reset, read 0x7FF63..0x7FF6F -> 00,00,00,01. Read 0x7FFFB -> 00. Decode 0xC30000/AM 0x39 -> hit=0.
- Write ADER1 = 0x00C000E4 (base 0xC00000, AM 0x39) via bytes 00,C0,00,E4 at 0x7FF73/77/7B/7F. Write ADER0=1. Write 0x10 to 0x7FFFB -> module_en_o=1. Decode 0xC30000/AM 0x39 -> hit=1, func=1, local=0x030000 one cycle later.
- With the same setup, decode 0xC30000/AM 0x09 -> hit=0. Decode 0xC80000/AM 0x39 -> hit=0. Decode 0xC7FFFC/AM 0x39 -> hit=1, local=0x07FFFC.
- Write 0x10 to BIT_CLR 0x7FFF7 -> module_en_o=0. Decode 0xC20000 -> hit=0. Read 0x7FFFB -> 00.
- Write 0x01 to 0x7FF33 -> user_ctrl_o=0x01. Read back 0x01 with ack one cycle after the strobe. Read 0x00010 -> 0x00 with ack.
- Assert rst_i asynchronously mid-decode -> all outputs 0 immediately, and ADER reads return 00,00,00,01 afterwards.

Source files
------------

// File: rtl/svec_vme_func_decoder_if.sv
// rtl/svec_vme_func_decoder_if.sv - CR/CSR byte access and VME decode bus bundle
interface svec_vme_func_decoder_if;
  logic        csr_we_i;
  logic        csr_re_i;
  logic [18:0] csr_addr_i;
  logic [7:0]  csr_data_i;
  logic [7:0]  csr_data_o;
  logic        csr_ack_o;
  logic        dec_valid_i;
  logic [31:0] dec_addr_i;
  logic [5:0]  dec_am_i;
  logic        dec_hit_o;
  logic        dec_func_o;
  logic [31:0] dec_local_addr_o;

  modport master (
    output csr_we_i, csr_re_i, csr_addr_i, csr_data_i,
    output dec_valid_i, dec_addr_i, dec_am_i,
    input  csr_data_o, csr_ack_o,
    input  dec_hit_o, dec_func_o, dec_local_addr_o
  );

  modport slave (
    input  csr_we_i, csr_re_i, csr_addr_i, csr_data_i,
    input  dec_valid_i, dec_addr_i, dec_am_i,
    output csr_data_o, csr_ack_o,
    output dec_hit_o, dec_func_o, dec_local_addr_o
  );
endinterface

// File: rtl/svec_vme_func_decoder.sv
// rtl/svec_vme_func_decoder.sv - VME64x ADER/BIT_SET/user CSR registers and two-function address decoder
module svec_vme_func_decoder #(
  parameter logic [31:0] g_adem0 = 32'hFF000000,
  parameter logic [31:0] g_adem1 = 32'h00F80000
) (
  input  logic                         clk_sys_i,
  input  logic                         rst_i,
  svec_vme_func_decoder_if.slave       bus,
  output logic                         module_en_o,
  output logic [7:0]                   user_ctrl_o
);

  logic [31:0] ader0, ader1, ader0_nx, ader1_nx;
  logic        module_en_nx;
  logic [7:0]  user_ctrl_nx;
  logic [7:0]  rd_data;
  logic        hit0, hit1;

  // Next-state of the CSR registers; the read mux looks at these so a
  // simultaneous write+read returns the freshly written value.
  always_comb begin
    ader0_nx     = ader0;
    ader1_nx     = ader1;
    module_en_nx = module_en_o;
    user_ctrl_nx = user_ctrl_o;
    if (bus.csr_we_i) begin
      case (bus.csr_addr_i)
        19'h7FF63: ader0_nx[31:24] = bus.csr_data_i;
        19'h7FF67: ader0_nx[23:16] = bus.csr_data_i;
        19'h7FF6B: ader0_nx[15:8]  = bus.csr_data_i;
        19'h7FF6F: ader0_nx[7:0]   = bus.csr_data_i;
        19'h7FF73: ader1_nx[31:24] = bus.csr_data_i;
        19'h7FF77: ader1_nx[23:16] = bus.csr_data_i;
        19'h7FF7B: ader1_nx[15:8]  = bus.csr_data_i;
        19'h7FF7F: ader1_nx[7:0]   = bus.csr_data_i;
        19'h7FF33: user_ctrl_nx    = bus.csr_data_i;
        19'h7FFFB: module_en_nx    = module_en_o | bus.csr_data_i[4];
        19'h7FFF7: module_en_nx    = module_en_o & ~bus.csr_data_i[4];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (bus.csr_addr_i)
      19'h7FF63: rd_data = ader0_nx[31:24];
      19'h7FF67: rd_data = ader0_nx[23:16];
      19'h7FF6B: rd_data = ader0_nx[15:8];
      19'h7FF6F: rd_data = ader0_nx[7:0];
      19'h7FF73: rd_data = ader1_nx[31:24];
      19'h7FF77: rd_data = ader1_nx[23:16];
      19'h7FF7B: rd_data = ader1_nx[15:8];
      19'h7FF7F: rd_data = ader1_nx[7:0];
      19'h7FF33: rd_data = user_ctrl_nx;
      19'h7FFFB,
      19'h7FFF7: rd_data = {3'b000, module_en_nx, 4'b0000};
      default:   rd_data = 8'h00;
    endcase
  end

  // Base compare ignores the AM/XAM byte of the ADER regardless of the mask.
  always_comb begin
    hit0 = module_en_o && !ader0[0]
        && ((bus.dec_addr_i & g_adem0) == (ader0 & g_adem0 & 32'hFFFFFF00))
        && (bus.dec_am_i == ader0[7:2]);
    hit1 = module_en_o && !ader1[0]
        && ((bus.dec_addr_i & g_adem1) == (ader1 & g_adem1 & 32'hFFFFFF00))
        && (bus.dec_am_i == ader1[7:2]);
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      ader0                <= 32'h00000001;
      ader1                <= 32'h00000001;
      module_en_o          <= 1'b0;
      user_ctrl_o          <= 8'h00;
      bus.csr_ack_o        <= 1'b0;
      bus.csr_data_o       <= 8'h00;
      bus.dec_hit_o        <= 1'b0;
      bus.dec_func_o       <= 1'b0;
      bus.dec_local_addr_o <= 32'h0;
    end else begin
      ader0         <= ader0_nx;
      ader1         <= ader1_nx;
      module_en_o   <= module_en_nx;
      user_ctrl_o   <= user_ctrl_nx;
      bus.csr_ack_o <= bus.csr_we_i | bus.csr_re_i;
      if (bus.csr_re_i)
        bus.csr_data_o <= rd_data;
      if (bus.dec_valid_i) begin
        if (hit0) begin
          bus.dec_hit_o        <= 1'b1;
          bus.dec_func_o       <= 1'b0;
          bus.dec_local_addr_o <= bus.dec_addr_i & ~g_adem0;
        end else if (hit1) begin
          bus.dec_hit_o        <= 1'b1;
          bus.dec_func_o       <= 1'b1;
          bus.dec_local_addr_o <= bus.dec_addr_i & ~g_adem1;
        end else begin
          bus.dec_hit_o        <= 1'b0;
          bus.dec_func_o       <= 1'b0;
          bus.dec_local_addr_o <= 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_svec_vme_func_decoder.sv
// tb/tb_svec_vme_func_decoder.sv - scoreboard bench for the SVEC VME function decoder
module tb_svec_vme_func_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       module_en;
  logic [7:0] user_ctrl;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       chk;
    logic [7:0] data;
  } csr_exp_t;

  typedef struct {
    logic        hit;
    logic        func;
    logic [31:0] laddr;
  } dec_exp_t;

  csr_exp_t csr_q[$];
  dec_exp_t dec_q[$];

  svec_vme_func_decoder_if bus ();

  svec_vme_func_decoder dut (
    .clk_sys_i   (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .module_en_o (module_en),
    .user_ctrl_o (user_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [18:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.csr_we_i   = 1'b1;
    bus.csr_addr_i = addr;
    bus.csr_data_i = data;
    csr_q.push_back('{1'b0, 8'h00});
    @(negedge clk);
    bus.csr_we_i   = 1'b0;
  endtask

  task automatic csr_rd(input logic [18:0] addr, input logic [7:0] exp);
    @(negedge clk);
    bus.csr_re_i   = 1'b1;
    bus.csr_addr_i = addr;
    csr_q.push_back('{1'b1, exp});
    @(negedge clk);
    bus.csr_re_i   = 1'b0;
  endtask

  task automatic csr_wr_rd(input logic [18:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.csr_we_i   = 1'b1;
    bus.csr_re_i   = 1'b1;
    bus.csr_addr_i = addr;
    bus.csr_data_i = data;
    csr_q.push_back('{1'b1, data});
    @(negedge clk);
    bus.csr_we_i   = 1'b0;
    bus.csr_re_i   = 1'b0;
  endtask

  task automatic dec(input logic [31:0] addr, input logic [5:0] am,
                     input logic hit, input logic func, input logic [31:0] laddr);
    @(negedge clk);
    bus.dec_valid_i = 1'b1;
    bus.dec_addr_i  = addr;
    bus.dec_am_i    = am;
    dec_q.push_back('{hit, func, laddr});
    @(negedge clk);
    bus.dec_valid_i = 1'b0;
  endtask

  // Monitor: ack must follow every strobe by one cycle; pops expectations on ack / decode.
  initial begin
    logic s_stb, s_dv, s_rst;
    csr_exp_t ce;
    dec_exp_t de;
    forever begin
      @(posedge clk);
      s_stb = bus.csr_we_i | bus.csr_re_i;
      s_dv  = bus.dec_valid_i;
      s_rst = rst;
      #1;
      if (!s_rst && !rst) begin
        chk("csr_ack", {31'b0, bus.csr_ack_o}, {31'b0, s_stb});
        if (bus.csr_ack_o) begin
          if (csr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL csr_unexpected_ack actual 1 required 0");
          end else begin
            ce = csr_q.pop_front();
            if (ce.chk) chk("csr_rdata", {24'b0, bus.csr_data_o}, {24'b0, ce.data});
          end
        end
        if (s_dv) begin
          if (dec_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dec_unexpected actual 1 required 0");
          end else begin
            de = dec_q.pop_front();
            chk("dec_hit",   {31'b0, bus.dec_hit_o},  {31'b0, de.hit});
            chk("dec_func",  {31'b0, bus.dec_func_o}, {31'b0, de.func});
            chk("dec_local", bus.dec_local_addr_o,    de.laddr);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.csr_we_i    = 1'b0;
    bus.csr_re_i    = 1'b0;
    bus.csr_addr_i  = '0;
    bus.csr_data_i  = '0;
    bus.dec_valid_i = 1'b0;
    bus.dec_addr_i  = '0;
    bus.dec_am_i    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_module_en", {31'b0, module_en}, 32'h0);
    chk("rst_user_ctrl", {24'b0, user_ctrl}, 32'h0);
    chk("rst_hit",       {31'b0, bus.dec_hit_o}, 32'h0);
    chk("rst_csr_data",  {24'b0, bus.csr_data_o}, 32'h0);

    csr_rd(19'h7FF63, 8'h00);
    csr_rd(19'h7FF67, 8'h00);
    csr_rd(19'h7FF6B, 8'h00);
    csr_rd(19'h7FF6F, 8'h01);
    csr_rd(19'h7FFFB, 8'h00);
    dec(32'h00C30000, 6'h39, 1'b0, 1'b0, 32'h0);

    // ADER1 = 0x00C000E4 : base 0xC00000, AM 0x39
    csr_wr(19'h7FF73, 8'h00);
    csr_wr(19'h7FF77, 8'hC0);
    csr_wr(19'h7FF7B, 8'h00);
    csr_wr(19'h7FF7F, 8'hE4);
    csr_wr(19'h7FF63, 8'h00);
    csr_wr(19'h7FF67, 8'h00);
    csr_wr(19'h7FF6B, 8'h00);
    csr_wr(19'h7FF6F, 8'h01);
    dec(32'h00C30000, 6'h39, 1'b0, 1'b0, 32'h0);
    csr_wr(19'h7FFFB, 8'h10);
    chk("module_en_set", {31'b0, module_en}, 32'h1);
    csr_rd(19'h7FFFB, 8'h10);
    csr_rd(19'h7FF77, 8'hC0);
    csr_rd(19'h7FF7F, 8'hE4);

    dec(32'h00C30000, 6'h39, 1'b1, 1'b1, 32'h00030000);
    dec(32'h00C30000, 6'h09, 1'b0, 1'b0, 32'h0);
    dec(32'h00C80000, 6'h39, 1'b0, 1'b0, 32'h0);
    dec(32'h00C7FFFC, 6'h39, 1'b1, 1'b1, 32'h0007FFFC);
    dec(32'h00C00000, 6'h39, 1'b1, 1'b1, 32'h0);

    csr_wr(19'h7FFF7, 8'hEF);
    chk("bit_clr_ignores_other_bits", {31'b0, module_en}, 32'h1);
    csr_wr(19'h7FFF7, 8'h10);
    chk("module_en_clr", {31'b0, module_en}, 32'h0);
    dec(32'h00C20000, 6'h39, 1'b0, 1'b0, 32'h0);
    csr_rd(19'h7FFFB, 8'h00);

    csr_wr(19'h7FF33, 8'h01);
    chk("user_ctrl", {24'b0, user_ctrl}, 32'h01);
    csr_rd(19'h7FF33, 8'h01);
    csr_rd(19'h00010, 8'h00);
    csr_wr(19'h00010, 8'hFF);
    csr_wr_rd(19'h7FF33, 8'h5A);
    chk("user_ctrl_wr_rd", {24'b0, user_ctrl}, 32'h5A);

    csr_wr(19'h7FFFB, 8'h10);
    @(negedge clk);
    bus.dec_valid_i = 1'b1;
    bus.dec_addr_i  = 32'h00C30000;
    bus.dec_am_i    = 6'h39;
    dec_q.push_back('{1'b1, 1'b1, 32'h00030000});
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_hit",       {31'b0, bus.dec_hit_o}, 32'h0);
    chk("arst_func",      {31'b0, bus.dec_func_o}, 32'h0);
    chk("arst_local",     bus.dec_local_addr_o, 32'h0);
    chk("arst_ack",       {31'b0, bus.csr_ack_o}, 32'h0);
    chk("arst_csr_data",  {24'b0, bus.csr_data_o}, 32'h0);
    chk("arst_module_en", {31'b0, module_en}, 32'h0);
    chk("arst_user_ctrl", {24'b0, user_ctrl}, 32'h0);
    @(negedge clk);
    bus.dec_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    csr_rd(19'h7FF73, 8'h00);
    csr_rd(19'h7FF77, 8'h00);
    csr_rd(19'h7FF7B, 8'h00);
    csr_rd(19'h7FF7F, 8'h01);
    csr_rd(19'h7FF6F, 8'h01);

    repeat (3) @(negedge clk);
    chk("csr_queue_drained", csr_q.size(), 32'h0);
    chk("dec_queue_drained", dec_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
